layer_priority_arbiter: RTL

Registered pixel arbiter and priority scheduler for the VGA object layers. It chooses which of NUM_LAYERS drawing requesters owns each pixel, using a rank table that software or game logic reprograms through a valid/ready port. New ranks take effect only at frame boundaries. The block also applies per-layer blink masking and reports per-frame collisions. It sits between the object drawers and the VGA output stage, taking over the fixed-priority object multiplexing.

---
 rtl/layer_priority_arbiter.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/layer_priority_arbiter.sv
// layer_priority_arbiter
//   Registered pixel arbiter for the VGA object layers. For every pixel it picks
//   the enabled layer with the lowest active rank. Ranks are reprogrammed
//   through a valid/ready port into a shadow table, which is copied to the
//   active table at the frame boundary. Per-layer blink masking and per-frame
//   collision reporting are also done here.
//
// State table:
//   INIT | one cycle after reset, config port closed
//   RUN  | normal operation, config port open except on startOfFrame cycles
//
// Ports:
//   clk, resetN          pixel clock, synchronous active-low reset
//   startOfFrame         one-cycle pulse on the first pixel of a frame
//   drawingRequest       per-layer request for the current pixel
//   layerRGB             per-layer colour, layer i in [8i+7:8i]
//   backGroundRGB        colour used when no enabled layer requests
//   blinkEn              per-layer blink masking enable
//   cfgValid/cfgReady    rank write handshake
//   cfgLayer, cfgRank    rank write payload (out-of-range values ignored)
//   RGBOut, winLayer     registered winning colour / layer (NUM_LAYERS = bg)
//   collision            registered, two or more enabled layers requested
//   frameCollision       sticky collision flag for the current frame
module layer_priority_arbiter #(
  parameter int NUM_LAYERS   = 4,
  parameter int BLINK_FRAMES = 16
) (
  input  logic                    clk,
  input  logic                    resetN,
  input  logic                    startOfFrame,
  input  logic [NUM_LAYERS-1:0]   drawingRequest,
  input  logic [8*NUM_LAYERS-1:0] layerRGB,
  input  logic [7:0]              backGroundRGB,
  input  logic [NUM_LAYERS-1:0]   blinkEn,
  input  logic                    cfgValid,
  input  logic [2:0]              cfgLayer,
  input  logic [2:0]              cfgRank,
  output logic                    cfgReady,
  output logic [7:0]              RGBOut,
  output logic [3:0]              winLayer,
  output logic                    collision,
  output logic                    frameCollision
);

  localparam int FCW = (BLINK_FRAMES > 2) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [3:0] NL = 4'(NUM_LAYERS);

  typedef enum logic {INIT, RUN} state_t;

  state_t          r_state, w_stateNext;
  logic [2:0]      r_shadow [NUM_LAYERS];
  logic [2:0]      r_active [NUM_LAYERS];
  logic [FCW-1:0]  r_frameCnt;

  logic            w_accept;
  logic            w_cfgInRange;
  logic [2:0]      w_oldRank;
  logic            w_blinkOff;
  logic [NUM_LAYERS-1:0] w_enabled;
  logic [3:0]      w_bestRank;
  logic [3:0]      w_win;
  logic [7:0]      w_rgb;
  logic [3:0]      w_count;
  logic            w_collision;

  // ---------------- control FSM ----------------
  always_ff @(posedge clk) begin
    if (!resetN) r_state <= INIT;
    else         r_state <= w_stateNext;
  end

  always_comb begin
    w_stateNext = r_state;
    cfgReady    = 1'b0;
    case (r_state)
      INIT: w_stateNext = RUN;
      RUN:  cfgReady    = !startOfFrame;
      default: w_stateNext = INIT;
    endcase
  end

  assign w_accept     = cfgValid && cfgReady;
  assign w_cfgInRange = ({1'b0, cfgLayer} < NL) && ({1'b0, cfgRank} < NL);

  always_comb begin
    w_oldRank = '0;
    for (int i = 0; i < NUM_LAYERS; i++)
      if (3'(i) == cfgLayer) w_oldRank = r_shadow[i];
  end

  // ---------------- rank tables ----------------
  // The layer currently holding the target rank inherits the written layer's
  // old rank, so the shadow table remains a permutation.
  always_ff @(posedge clk) begin
    if (!resetN) begin
      for (int i = 0; i < NUM_LAYERS; i++) begin
        r_shadow[i] <= 3'(i);
        r_active[i] <= 3'(i);
      end
    end else begin
      if (w_accept && w_cfgInRange) begin
        for (int i = 0; i < NUM_LAYERS; i++) begin
          if (3'(i) == cfgLayer)         r_shadow[i] <= cfgRank;
          else if (r_shadow[i] == cfgRank) r_shadow[i] <= w_oldRank;
        end
      end
      if (startOfFrame && r_state == RUN) begin
        for (int i = 0; i < NUM_LAYERS; i++)
          r_active[i] <= r_shadow[i];
      end
    end
  end

  // ---------------- blink frame counter ----------------
  always_ff @(posedge clk) begin
    if (!resetN) r_frameCnt <= '0;
    else if (startOfFrame) begin
      if (r_frameCnt == FCW'(BLINK_FRAMES - 1)) r_frameCnt <= '0;
      else                                      r_frameCnt <= r_frameCnt + 1'b1;
    end
  end

  assign w_blinkOff = (32'(r_frameCnt) >= 32'(BLINK_FRAMES / 2));

  // ---------------- arbitration ----------------
  // Ranks are unique, so a strict less-than scan yields a single winner.
  always_comb begin
    w_enabled  = '0;
    w_bestRank = NL;
    w_win      = NL;
    w_rgb      = backGroundRGB;
    w_count    = '0;
    for (int i = 0; i < NUM_LAYERS; i++)
      w_enabled[i] = drawingRequest[i] && !(blinkEn[i] && w_blinkOff);
    for (int i = 0; i < NUM_LAYERS; i++) begin
      if (w_enabled[i] && ({1'b0, r_active[i]} < w_bestRank)) begin
        w_bestRank = {1'b0, r_active[i]};
        w_win      = 4'(i);
        w_rgb      = layerRGB[8*i +: 8];
      end
      w_count = w_count + {3'b000, w_enabled[i]};
    end
  end

  assign w_collision = (w_count >= 4'd2);

  // ---------------- registered pixel outputs ----------------
  always_ff @(posedge clk) begin
    if (!resetN) begin
      RGBOut         <= '0;
      winLayer       <= NL;
      collision      <= 1'b0;
      frameCollision <= 1'b0;
    end else begin
      RGBOut    <= w_rgb;
      winLayer  <= w_win;
      collision <= w_collision;
      // Clear at the frame edge but keep a collision on the first pixel.
      if (startOfFrame) frameCollision <= w_collision;
      else              frameCollision <= frameCollision | w_collision;
    end
  end

endmodule
